seq_alu: RTL

Parametrised, registered successor to the team's 4-bit combinational ALU: a WIDTH-bit ALU with a valid/ready operand interface, a registered result with status flags, and a multi-cycle shift-add multiplier. It sits between the switch/pin input logic and the output pins, and can also be driven by a sequencer. Single-cycle ops have throughput of one result per clock; MUL occupies the unit for WIDTH cycles.

---
 rtl/seq_alu_if.sv | 31 +++
 rtl/seq_alu.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// seq_alu operand/result bundle: valid/ready operand channel in,
// valid/ready result channel with status flags out.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, op, x, y, out_ready,
        input  in_ready, out_valid, result, result_hi,
        input  carry, overflow, zero, negative
    );

    modport slave (
        input  in_valid, op, x, y, out_ready,
        output in_ready, out_valid, result, result_hi,
        output carry, overflow, zero, negative
    );
endinterface

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with status flags and a serial
// shift-add multiplier (one multiplier bit per cycle, LSB first).
module seq_alu #(
    parameter int WIDTH = 8
) (
    input logic     clk,
    input logic     rst,
    seq_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;

    logic               accept;
    logic               consume;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH:0]     step_s;
    logic [2*WIDTH-1:0] prod_nx;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    assign bus.in_ready = (state == S_IDLE) &&
                          (!bus.out_valid || bus.out_ready);
    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.out_valid && bus.out_ready;

    assign add_s = {1'b0, bus.x} + {1'b0, bus.y};
    assign sub_s = {1'b0, bus.x} + {1'b0, ~bus.y} + (WIDTH+1)'(1);

    // prod holds {partial product, remaining multiplier bits};
    // each step adds the multiplicand on bit 0 and shifts right.
    assign step_s  = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                     {1'b0, {WIDTH{prod[0]}} & mcand};
    assign prod_nx = {step_s, prod[WIDTH-1:1]};

    // Single-cycle op evaluation on the live operands.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (bus.op)
            OP_ADD: begin
                alu_res = add_s[WIDTH-1:0];
                alu_c   = add_s[WIDTH];
                alu_v   = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) &&
                          (add_s[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_s[WIDTH-1:0];
                alu_c   = sub_s[WIDTH];
                alu_v   = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) &&
                          (sub_s[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_XOR:  alu_res = bus.x ^ bus.y;
            OP_AND:  alu_res = bus.x & bus.y;
            OP_OR:   alu_res = bus.x | bus.y;
            OP_SHL: begin
                alu_res = {bus.x[WIDTH-2:0], 1'b0};
                alu_c   = bus.x[WIDTH-1];
            end
            OP_MUL:  alu_res = '0;
            OP_PASS: alu_res = bus.y;
        endcase
    end

    // Control FSM plus result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            mcand         <= '0;
            prod          <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.zero      <= 1'b0;
            bus.negative  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.op == OP_MUL) begin
                            mcand         <= bus.x;
                            prod          <= {{WIDTH{1'b0}}, bus.y};
                            cnt           <= CW'(WIDTH-1);
                            state         <= S_MUL;
                            bus.out_valid <= 1'b0;
                        end else begin
                            bus.result    <= alu_res;
                            bus.result_hi <= '0;
                            bus.carry     <= alu_c;
                            bus.overflow  <= alu_v;
                            bus.zero      <= (alu_res == '0);
                            bus.negative  <= alu_res[WIDTH-1];
                            bus.out_valid <= 1'b1;
                        end
                    end else if (consume) begin
                        bus.out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    prod <= prod_nx;
                    if (cnt == '0) begin
                        bus.result    <= prod_nx[WIDTH-1:0];
                        bus.result_hi <= prod_nx[2*WIDTH-1:WIDTH];
                        bus.carry     <= |prod_nx[2*WIDTH-1:WIDTH];
                        bus.overflow  <= 1'b0;
                        bus.zero      <= (prod_nx == '0);
                        bus.negative  <= prod_nx[WIDTH-1];
                        bus.out_valid <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end
endmodule
